// File: rtl/tile_bank_arbiter.sv
// Per-bank round-robin arbiter sharing tile memory banks among NUM_REQ requesters,
// with fixed-latency read-data return. Optional macro TILE_ARB_FIXED_PRI_EN gives req 0 absolute priority.
module tile_bank_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned BANKS   = 4,
    parameter int unsigned BANK_W  = 2,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*BANK_W-1:0]   req_bank,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic [NUM_REQ*DATA_W-1:0]   resp_rdata,
    output logic [BANKS-1:0]            bank_enable,
    output logic [BANKS-1:0]            bank_write_en,
    output logic [BANKS*ADDR_W-1:0]     bank_addr,
    output logic [BANKS*DATA_W-1:0]     bank_wdata,
    input  logic [BANKS*DATA_W-1:0]     bank_rdata,
    input  logic [BANKS-1:0]            bank_ready
);

    localparam int unsigned REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [REQ_W-1:0]   ptr     [BANKS];
    logic [NUM_REQ-1:0] cand    [BANKS];
    logic [NUM_REQ-1:0] oob;
    logic [BANKS-1:0]   hi_f;
    logic [BANKS-1:0]   lo_f;
    logic [REQ_W-1:0]   hi_id   [BANKS];
    logic [REQ_W-1:0]   lo_id   [BANKS];
    logic [BANKS-1:0]   win_found;
    logic [REQ_W-1:0]   win_id  [BANKS];
    logic [BANKS-1:0]   accept;
    logic [BANKS-1:0]   rd_accept;

    // Read-return pipelines: per bank {valid, requester}, per requester for out-of-range reads
    logic [BANKS-1:0]   tag_v   [RD_LAT];
    logic [REQ_W-1:0]   tag_id  [RD_LAT][BANKS];
    logic [NUM_REQ-1:0] oob_v   [RD_LAT];

    // Decode each request into a bank candidate bit or an out-of-range flag
    always_comb begin
        oob = '0;
        for (int b = 0; b < BANKS; b++) begin
            cand[b] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (32'(req_bank[i*BANK_W +: BANK_W]) >= BANKS) begin
                    oob[i] = 1'b1;
                end else begin
                    for (int b = 0; b < BANKS; b++) begin
                        if (req_bank[i*BANK_W +: BANK_W] == BANK_W'(b)) begin
                            cand[b][i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Round robin: lowest candidate above ptr, else lowest candidate at or below ptr
    always_comb begin
        hi_f      = '0;
        lo_f      = '0;
        win_found = '0;
        for (int b = 0; b < BANKS; b++) begin
            hi_id[b]  = '0;
            lo_id[b]  = '0;
            win_id[b] = '0;
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (cand[b][i]) begin
                    if (REQ_W'(i) > ptr[b]) begin
                        hi_f[b]  = 1'b1;
                        hi_id[b] = REQ_W'(i);
                    end else begin
                        lo_f[b]  = 1'b1;
                        lo_id[b] = REQ_W'(i);
                    end
                end
            end
            win_found[b] = hi_f[b] | lo_f[b];
            win_id[b]    = hi_f[b] ? hi_id[b] : lo_id[b];
`ifdef TILE_ARB_FIXED_PRI_EN
            if (cand[b][0]) begin
                win_id[b] = '0;
            end
`endif
        end
    end

    // Bank port drive and requester handshake; everything held off while in reset
    always_comb begin
        req_ready     = '0;
        bank_enable   = '0;
        bank_write_en = '0;
        bank_addr     = '0;
        bank_wdata    = '0;
        accept        = '0;
        rd_accept     = '0;
        for (int b = 0; b < BANKS; b++) begin
            accept[b] = !rst && bank_ready[b] && win_found[b];
            if (accept[b]) begin
                bank_enable[b]                   = 1'b1;
                bank_write_en[b]                 = req_we[win_id[b]];
                bank_addr[b*ADDR_W +: ADDR_W]    = req_addr[32'(win_id[b])*ADDR_W +: ADDR_W];
                bank_wdata[b*DATA_W +: DATA_W]   = req_wdata[32'(win_id[b])*DATA_W +: DATA_W];
                req_ready[win_id[b]]             = 1'b1;
                rd_accept[b]                     = !req_we[win_id[b]];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && oob[i]) begin
                req_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin
                ptr[b] <= REQ_W'(NUM_REQ - 1);
            end
        end else begin
            for (int b = 0; b < BANKS; b++) begin
`ifdef TILE_ARB_FIXED_PRI_EN
                if (accept[b] && win_id[b] != '0) begin
                    ptr[b] <= win_id[b];
                end
`else
                if (accept[b]) begin
                    ptr[b] <= win_id[b];
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                tag_v[s] <= '0;
                oob_v[s] <= '0;
                for (int b = 0; b < BANKS; b++) begin
                    tag_id[s][b] <= '0;
                end
            end
        end else begin
            tag_v[0] <= rd_accept;
            oob_v[0] <= oob & ~req_we;
            for (int b = 0; b < BANKS; b++) begin
                tag_id[0][b] <= win_id[b];
            end
            for (int s = 1; s < RD_LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                oob_v[s]  <= oob_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    // Pipeline tail: capture bank data into the issuing requester's response register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= '0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= '0;
            for (int b = 0; b < BANKS; b++) begin
                if (tag_v[RD_LAT-1][b]) begin
                    resp_valid[tag_id[RD_LAT-1][b]] <= 1'b1;
                    resp_rdata[32'(tag_id[RD_LAT-1][b])*DATA_W +: DATA_W] <= bank_rdata[b*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (oob_v[RD_LAT-1][i]) begin
                    resp_valid[i]                  <= 1'b1;
                    resp_rdata[i*DATA_W +: DATA_W] <= '0;
                end
            end
        end
    end

endmodule

// File: doc/tile_bank_arbiter.md
Name: tile_bank_arbiter

Overview:
- Per-bank round-robin arbiter that shares the tile memory banks between NUM_REQ requesters: tile controller (req 0), NoC memory port (req 1) and PE accumulator writeback (req 2).
- Sits between the requesters and the tile memory bank ports.
- Routes read data back to the issuing requester using a fixed-latency tag pipeline per bank.

Parameters:
- NUM_REQ, 3, number of requesters
- BANKS, 4, number of memory banks
- BANK_W, 2, width of the bank-select field
- ADDR_W, 13, bank word address width
- DATA_W, 64, data width
- RD_LAT, 1, bank read latency in cycles from accept to rdata (valid range 1..4)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted this cycle
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_bank  in  NUM_REQ*BANK_W  target bank, flattened (req i at [i*BANK_W +: BANK_W])
- req_addr  in  NUM_REQ*ADDR_W  word address, flattened
- req_wdata  in  NUM_REQ*DATA_W  write data, flattened
- resp_valid  out  NUM_REQ  read data valid, registered
- resp_rdata  out  NUM_REQ*DATA_W  read data, flattened, registered
- bank_enable  out  BANKS  bank access strobe
- bank_write_en  out  BANKS  bank write strobe
- bank_addr  out  BANKS*ADDR_W  per-bank address
- bank_wdata  out  BANKS*DATA_W  per-bank write data
- bank_rdata  in  BANKS*DATA_W  per-bank read data, valid RD_LAT cycles after accept
- bank_ready  in  BANKS  bank can accept an access this cycle

Behaviour:
- Reset (rst high, asynchronous):
  - resp_valid = 0, resp_rdata = 0.
  - All tag pipelines cleared.
  - All RR pointers = NUM_REQ-1, so req 0 has first priority.
  - req_ready, bank_enable and bank_write_en forced to 0 while rst is high.
- Arbitration, per bank b, combinational:
  - Candidates are requesters with req_valid=1 and req_bank=b.
  - Winner is the first candidate after ptr[b], searched cyclically upward.
- Accept (transfer):
  - Occurs when bank_ready[b]=1 and a winner exists.
  - Drives bank_enable[b]=1, bank_write_en[b]=req_we, and addr/wdata from the winner.
  - req_ready[winner]=1.
  - ptr[b] <= winner on the clock edge.
  - ptr[b] does not update when bank_ready[b]=0; the same winner is re-evaluated next cycle.
- No grant: bank_enable[b]=0, bank_addr and bank_wdata are 0 for that bank.
- Concurrency: each requester targets one bank per cycle, so different banks grant different requesters in the same cycle with no conflict.
- Request stability: a requester holds valid/we/bank/addr/wdata stable until req_ready. The arbiter does not check this.
- Out-of-range bank (req_bank >= BANKS):
  - Accepted immediately with req_ready=1.
  - No bank access is made.
  - A read returns resp_rdata=0 with resp_valid after RD_LAT+1 cycles. A write is dropped.
- Read return:
  - Per bank, an RD_LAT-deep shift pipeline carries {valid, requester index}.
  - A read accept enters {1, i}; all other cycles enter {0, x}.
  - At the tail, resp_valid[i] <= 1 and resp_rdata[i] <= bank_rdata[b], registered.
  - Total latency from req_ready to resp_valid is RD_LAT+1 cycles.
  - Responses per requester arrive in issue order.
- Writes produce no response.
- resp_valid is a single-cycle pulse per read. resp_rdata holds its last value when resp_valid=0.
- Reset mid-operation: in-flight reads are discarded and no resp_valid is produced for them after rst deasserts.

Optional Feature:
- TILE_ARB_FIXED_PRI_EN defined:
  - Req 0 (controller) always wins any bank it requests.
  - RR among the remaining requesters is unchanged.
  - ptr[b] is not updated on req-0 grants.
- Not defined: pure round-robin, as described above.

Test Plan:
- Single read: req1 bank 2 addr 0x0040, bank_ready=1, bank_rdata[2]=0xDEAD_BEEF_0000_0001 (RD_LAT=1) -> req_ready[1] in cycle 0, bank_enable=4'b0100, resp_valid[1] in cycle 2 with that data.
- Contention: req0, req1, req2 all read bank 0 continuously -> grants in order 0,1,2,0,1,2; one accept per cycle; each requester receives its own data.
- Parallel banks: req0→bank0 write 0x11, req1→bank1 read, req2→bank3 write 0x33 in the same cycle -> all three req_ready=1; bank_enable=4'b1011; bank_write_en=4'b1001.
- Backpressure: bank_ready[0]=0 for 3 cycles with req1 pending -> req_ready[1]=0 and ptr unchanged; req1 granted the cycle bank_ready returns.
- Reset mid-flight: read accepted, then rst pulsed before the response -> resp_valid stays 0; after reset, req0 wins first under contention.
- With TILE_ARB_FIXED_PRI_EN: req0 and req2 continuously read bank 1 -> req0 granted every cycle and req2 starved. Without the macro the grants alternate.
